// File: rtl/ps2_ascii_queue_if.sv
// ps2_ascii_queue_if: byte-strobe input side and valid/ready character output
// side of the PS/2 scan-code to ASCII queue, plus its status signals.
// The slave modport is the queue itself; the master modport is its environment
// (PS/2 receiver driving bytes, console consumer taking characters).
interface ps2_ascii_queue_if #(
    parameter int AW = 3
);
    logic          in_valid;
    logic [7:0]    in_code;
    logic          out_valid;
    logic [7:0]    out_ascii;
    logic          out_ready;
    logic [AW:0]   count;
    logic          overflow;
    logic          caps_led;

    modport slave (
        input  in_valid, in_code, out_ready,
        output out_valid, out_ascii, count, overflow, caps_led
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  out_valid, out_ascii, count, overflow, caps_led
    );
endinterface

// File: rtl/ps2_ascii_queue.sv
// ps2_ascii_queue: decodes a PS/2 set-2 scan-code byte stream (F0 break and
// E0 extended prefixes, Shift, Caps Lock) into ASCII characters and buffers
// them in a first-word-fall-through FIFO with a valid/ready output.
// Optional build macro PS2_REPEAT_FILTER_EN: suppresses typematic repeats of
// the last make code until any break is seen.
module ps2_ascii_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic clk,
    input  logic rst,
    ps2_ascii_queue_if.slave bus
);
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_LSHFT = 8'h12;
    localparam logic [7:0] CODE_RSHFT = 8'h59;
    localparam logic [7:0] CODE_CAPS  = 8'h58;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;

    state_t state, state_nx;
    logic   make_evt, brk_evt, ext_brk_evt;

    // Prefix FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Prefix FSM next state and per-byte event decode.
    // NOTE: every output gets a default first so no path leaves one unassigned;
    // a missing default in combinational logic infers a latch.
    always_comb begin
        state_nx    = state;
        make_evt    = 1'b0;
        brk_evt     = 1'b0;
        ext_brk_evt = 1'b0;
        if (bus.in_valid) begin
            case (state)
                IDLE: begin
                    if (bus.in_code == CODE_BRK)      state_nx = BRK;
                    else if (bus.in_code == CODE_EXT) state_nx = EXT;
                    else                              make_evt = 1'b1;
                end
                BRK: begin
                    brk_evt  = 1'b1;
                    state_nx = IDLE;
                end
                EXT: begin
                    if (bus.in_code == CODE_BRK) state_nx = EXTBRK;
                    else                         state_nx = IDLE;
                end
                EXTBRK: begin
                    ext_brk_evt = 1'b1;
                    state_nx    = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    logic is_repeat;

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] last_code;
    logic       last_vld;

    // Remember the last non-extended make; any break forgets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld  <= 1'b0;
            last_code <= 8'h00;
        end else if (brk_evt || ext_brk_evt) begin
            last_vld  <= 1'b0;
        end else if (make_evt) begin
            last_vld  <= 1'b1;
            last_code <= bus.in_code;
        end
    end

    assign is_repeat = last_vld && (last_code == bus.in_code);
`else
    assign is_repeat = 1'b0;
`endif

    logic fresh_make;
    logic shift_l, shift_r, caps;

    assign fresh_make = make_evt && !is_repeat;

    // Modifier state: shift flags follow make/break, Caps toggles on each make.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            caps    <= 1'b0;
        end else begin
            if (fresh_make && bus.in_code == CODE_LSHFT) shift_l <= 1'b1;
            if (brk_evt    && bus.in_code == CODE_LSHFT) shift_l <= 1'b0;
            if (fresh_make && bus.in_code == CODE_RSHFT) shift_r <= 1'b1;
            if (brk_evt    && bus.in_code == CODE_RSHFT) shift_r <= 1'b0;
            if (fresh_make && bus.in_code == CODE_CAPS)  caps    <= ~caps;
        end
    end

    logic       shift;
    logic       char_vld;
    logic [7:0] char_val;
    logic [7:0] letter;
    logic       is_letter;

    assign shift = shift_l | shift_r;

    // Scan-code to ASCII lookup for make codes.
    always_comb begin
        letter    = 8'h00;
        is_letter = 1'b0;
        char_vld  = 1'b0;
        char_val  = 8'h00;
        case (bus.in_code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
        is_letter = (letter != 8'h00);
        if (is_letter) begin
            char_vld = 1'b1;
            char_val = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            char_vld = 1'b1;
            case (bus.in_code)
                8'h16: char_val = shift ? "!" : "1";
                8'h1E: char_val = shift ? "@" : "2";
                8'h26: char_val = shift ? "#" : "3";
                8'h25: char_val = shift ? "$" : "4";
                8'h2E: char_val = shift ? "%" : "5";
                8'h36: char_val = shift ? "^" : "6";
                8'h3D: char_val = shift ? "&" : "7";
                8'h3E: char_val = shift ? "*" : "8";
                8'h46: char_val = shift ? "(" : "9";
                8'h45: char_val = shift ? ")" : "0";
                8'h29: char_val = 8'h20;
                8'h5A: char_val = 8'h0D;
                8'h66: char_val = 8'h08;
                default: char_vld = 1'b0;
            endcase
        end
        if (!fresh_make) char_vld = 1'b0;
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          full, pop, push_ok;

    assign full    = (cnt == FULL_CNT);
    assign pop     = (cnt != '0) && bus.out_ready;
    assign push_ok = char_vld && (!full || pop);

    // FIFO storage.
    // NOTE: the data array has no reset; pointers and count define which
    // entries are valid, so clearing storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= char_val;
    end

    // FIFO pointers, exact occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (char_vld && full && !pop) ovf <= 1'b1;
        end
    end

    assign bus.out_valid = (cnt != '0);
    assign bus.out_ascii = (cnt != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.caps_led  = caps;
endmodule
